sqrt: RTL and testbench



---
 rtl/sqrt.sv | 83 ++++++++
 tb/tb_sqrt.sv | 103 ++++++++++
 2 files changed

// File: rtl/sqrt.sv
// Fully pipelined 32-bit unsigned integer square root: restoring digit-by-digit
// algorithm, one root bit per stage, result 16 clocks after the radicand is sampled.
module sqrt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] sqrt_a,
  output logic [31:0] sqrt_z
);

  localparam int unsigned STAGES = 16;

  logic [31:0] a_q;
  logic [17:0] rem_q  [STAGES-1];
  logic [17:0] rem_d  [STAGES-1];
  logic [15:0] root_q [STAGES];
  logic [15:0] root_d [STAGES];
  logic [31:0] rad_q  [STAGES-1];
  logic [31:0] rad_d  [STAGES-1];

  function automatic logic [17:0] shift_in(input logic [17:0] rem, input logic [1:0] pair);
    return (rem << 2) | {16'b0, pair};
  endfunction

  function automatic logic [17:0] trial_of(input logic [15:0] root);
    return {root, 2'b01};
  endfunction

  // The last stage only produces a root bit; its remainder and radicand are dropped.
  always_comb begin
    logic [17:0] rem_in;
    logic [15:0] root_in;
    logic [31:0] rad_in;
    logic [17:0] rem_sh;
    logic [17:0] trial;
    logic        fits;
    for (int unsigned i = 0; i < STAGES-1; i++) begin
      if (i == 0) begin
        rem_in  = '0;
        root_in = '0;
        rad_in  = a_q;
      end else begin
        rem_in  = rem_q[i-1];
        root_in = root_q[i-1];
        rad_in  = rad_q[i-1];
      end
      rem_sh    = shift_in(rem_in, rad_in[31:30]);
      trial     = trial_of(root_in);
      fits      = (rem_sh >= trial);
      rem_d[i]  = fits ? (rem_sh - trial) : rem_sh;
      root_d[i] = (root_in << 1) | {15'b0, fits};
      rad_d[i]  = rad_in << 2;
    end
    rem_sh = shift_in(rem_q[STAGES-2], rad_q[STAGES-2][31:30]);
    trial  = trial_of(root_q[STAGES-2]);
    fits   = (rem_sh >= trial);
    root_d[STAGES-1] = (root_q[STAGES-2] << 1) | {15'b0, fits};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      for (int unsigned i = 0; i < STAGES-1; i++) begin
        rem_q[i] <= '0;
        rad_q[i] <= '0;
      end
      for (int unsigned i = 0; i < STAGES; i++) begin
        root_q[i] <= '0;
      end
    end else begin
      a_q <= sqrt_a;
      for (int unsigned i = 0; i < STAGES-1; i++) begin
        rem_q[i] <= rem_d[i];
        rad_q[i] <= rad_d[i];
      end
      for (int unsigned i = 0; i < STAGES; i++) begin
        root_q[i] <= root_d[i];
      end
    end
  end

  assign sqrt_z = {16'b0, root_q[STAGES-1]};

endmodule

// File: tb/tb_sqrt.sv
// Self-checking bench for sqrt: directed boundaries plus random streaming,
// compared cycle by cycle against a binary-search floor-sqrt model with 16-cycle delay.
module tb_sqrt;

  logic        clk;
  logic        rst_n;
  logic [31:0] sqrt_a;
  logic [31:0] sqrt_z;

  int checks;
  int failures;

  // Expected outputs of inputs already sampled but not yet emerged (oldest first).
  logic [31:0] exp_q[$];

  sqrt dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sqrt_a (sqrt_a),
    .sqrt_z (sqrt_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_sqrt(input logic [31:0] a);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 65536;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= longint'(a)) lo = mid;
      else hi = mid;
    end
    return 32'(lo);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  // One clock: drive inputs, let the edge sample them, advance the model, compare.
  task automatic step(input logic [31:0] a, input logic rn, input string tag);
    logic [31:0] exp;
    @(negedge clk);
    sqrt_a = a;
    rst_n  = rn;
    @(posedge clk);
    #1;
    if (!rn) begin
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back(32'd0);
      exp = 32'd0;
    end else begin
      exp_q.push_back(ref_sqrt(a));
      exp = exp_q.pop_front();
    end
    check_eq(tag, sqrt_z, exp);
  endtask

  initial begin
    logic [31:0] bnd [8];
    int          sq  [5];
    logic [31:0] n2;

    checks   = 0;
    failures = 0;
    sqrt_a   = 32'hFFFF_FFFF;
    rst_n    = 1'b0;

    for (int i = 0; i < 3; i++) step(32'hFFFF_FFFF, 1'b0, "reset_hold");
    for (int i = 0; i < 17; i++) step(32'hFFFF_FFFF, 1'b1, "reset_release");

    bnd = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'hFFFF_FFFF, 32'd4294836225, 32'd4294836224};
    for (int i = 0; i < 8; i++) step(bnd[i], 1'b1, "boundary");

    sq = '{2, 255, 256, 4096, 46341};
    for (int i = 0; i < 5; i++) begin
      n2 = 32'(sq[i] * sq[i]);
      step(n2 - 32'd1, 1'b1, "square_m1");
      step(n2,         1'b1, "square");
      step(n2 + 32'd1, 1'b1, "square_p1");
    end

    for (int k = 0; k < 32; k++) step(32'd1 << k, 1'b1, "walking_bit");

    for (int i = 0; i < 5000; i++) step($urandom, 1'b1, "stream");

    for (int i = 0; i < 8; i++) step($urandom, 1'b1, "pre_reset");
    step($urandom, 1'b0, "midstream_reset");
    for (int i = 0; i < 20; i++) step($urandom, 1'b1, "post_reset");

    for (int i = 0; i < 16; i++) step(32'd0, 1'b1, "drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
